// File: rtl/seg7_pkg.sv
// Shared glyph table, FSM encoding and BCD sizing helpers for the sequential 7-segment formatter.
// Glyph bytes are {g,f,e,d,c,b,a,dp}, active-low.
package seg7_pkg;

  localparam logic [7:0] SEG_DIGIT [0:9] = '{
    8'b1000_0001, 8'b1111_0011, 8'b0100_1001, 8'b0110_0001, 8'b0011_0011,
    8'b0010_0101, 8'b0000_0101, 8'b1111_0001, 8'b0000_0001, 8'b0010_0001
  };
  localparam logic [7:0] SEG_DASH  = 8'b0111_1111;
  localparam logic [7:0] SEG_BLANK = 8'b1111_1111;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_ENCODE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // ceil(w * log10(2)) in integer arithmetic
  function automatic int bcd_width(input int w);
    return (w * 30103 + 99999) / 100000;
  endfunction

  // Register at least one BCD digit per display digit so capacity checks never index past the top.
  function automatic int bcd_regs(input int w, input int n);
    int b;
    b = bcd_width(w);
    return (b > n) ? b : n;
  endfunction

endpackage

// File: rtl/seg7_digit_enc.sv
// Combinational single-digit encoder: BCD digit plus dp/blank/dash controls to one active-low byte.
module seg7_digit_enc
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       dp,
  input  logic       blank,
  input  logic       dash,
  output logic [7:0] seg
);

  logic [7:0] base;

  always_comb begin
    base = SEG_BLANK;
    if (dash)
      base = SEG_DASH;
    else if (!blank && bcd <= 4'd9)
      base = SEG_DIGIT[bcd];
    seg = blank ? SEG_BLANK : (base & {7'h7F, ~dp});
  end

endmodule

// File: rtl/bin_to_7seg_seq.sv
// Iterative double-dabble binary-to-7-segment formatter with start/busy/done handshake,
// leading-zero blanking, decimal point, sign digit and overflow dashes.
module bin_to_7seg_seq
  import seg7_pkg::*;
#(
  parameter int WIDTH        = 14,
  parameter int NUM_DIGITS   = 4,
  parameter bit DASH_ON_ZERO = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [WIDTH-1:0]              value,
  input  logic                          negative,
  input  logic [$clog2(NUM_DIGITS+1)-1:0] dp_pos,
  input  logic                          blank_lz,
  output logic                          busy,
  output logic                          done,
  output logic                          overflow,
  output logic [8*NUM_DIGITS-1:0]       seg_out
);

  localparam int DPW   = $clog2(NUM_DIGITS + 1);
  localparam int BCD_N = bcd_regs(WIDTH, NUM_DIGITS);
  localparam int BW    = 4 * BCD_N;
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t                  state, next_state;
  logic [WIDTH-1:0]        bin_q;
  logic [BW-1:0]           bcd_q, bcd_adj;
  logic [CNT_W-1:0]        cnt_q;
  logic                    neg_q, blz_q;
  logic [DPW-1:0]          dp_q;
  logic [8*NUM_DIGITS-1:0] seg_q, enc_bytes;
  logic                    ovf_q, ovf, all_dash, upper_zero;
  logic [NUM_DIGITS-1:0]   dig_dp, dig_blank, dig_dash;
  int                      cap, dpk;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (start) next_state = S_SHIFT;
      S_SHIFT:  if (cnt_q == '0) next_state = S_ENCODE;
      S_ENCODE: next_state = S_DONE;
      S_DONE:   next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  assign busy     = (state == S_SHIFT) || (state == S_ENCODE);
  assign done     = (state == S_DONE);
  assign overflow = ovf_q;
  assign seg_out  = seg_q;

  // add-3 correction applied before each shift
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < BCD_N; i++)
      if (bcd_q[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      neg_q <= 1'b0;
      blz_q <= 1'b0;
      dp_q  <= '0;
      seg_q <= '1;
      ovf_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          bin_q <= value;
          bcd_q <= '0;
          cnt_q <= CNT_W'(WIDTH - 1);
          neg_q <= negative;
          blz_q <= blank_lz;
          dp_q  <= dp_pos;
        end
        S_SHIFT: begin
          bcd_q <= BW'({bcd_adj, bin_q[WIDTH-1]});
          bin_q <= bin_q << 1;
          cnt_q <= cnt_q - CNT_W'(1);
        end
        S_ENCODE: begin
          seg_q <= enc_bytes;
          ovf_q <= ovf;
        end
        default: ;
      endcase
    end
  end

  // Per-digit controls; the top digit is scanned first so upper_zero tracks "all zero from here up to CAP-1".
  always_comb begin
    cap = neg_q ? NUM_DIGITS - 1 : NUM_DIGITS;
    dpk = int'(dp_q);
    if (dpk > NUM_DIGITS) dpk = 0;
    ovf = 1'b0;
    for (int i = 0; i < BCD_N; i++)
      if (i >= cap && bcd_q[4*i +: 4] != 4'd0) ovf = 1'b1;
    all_dash   = ovf || (DASH_ON_ZERO && bcd_q == '0 && dpk != 0);
    upper_zero = 1'b1;
    dig_dp     = '0;
    dig_blank  = '0;
    dig_dash   = '0;
    for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
      if (d < cap) upper_zero = upper_zero && (bcd_q[4*d +: 4] == 4'd0);
      dig_dash[d]  = all_dash || (d >= cap);
      dig_dp[d]    = !all_dash && (dpk == d + 1);
      dig_blank[d] = !all_dash && (d < cap) && blz_q && (d > 0) && (d >= dpk) && upper_zero;
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_enc
    seg7_digit_enc u_enc (
      .bcd   (bcd_q[4*g +: 4]),
      .dp    (dig_dp[g]),
      .blank (dig_blank[g]),
      .dash  (dig_dash[g]),
      .seg   (enc_bytes[8*g +: 8])
    );
  end

endmodule
